// File: rtl/pid_error_stage.sv
// PID front end: latches a setpoint/feedback pair and produces the saturated
// error, its clamped running integral and its saturated first difference.
module pid_error_stage #(
  parameter logic signed [15:0] I_LIMIT = 16'sd16383
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] setpoint,
  input  logic signed [15:0] feedback,
  input  logic               clr_int,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] err,
  output logic signed [15:0] err_int,
  output logic signed [15:0] err_diff
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    ACC  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t state;

  logic signed [15:0] sp_reg;
  logic signed [15:0] fb_reg;
  logic signed [15:0] prev_err;

  logic signed [16:0] diff_wide;
  logic signed [16:0] sum_wide;
  logic signed [16:0] delta_wide;

  localparam logic signed [16:0] LIM_HI = {I_LIMIT[15], I_LIMIT};
  localparam logic signed [16:0] LIM_LO = -LIM_HI;

  // A 17-bit result overflows 16 bits exactly when its top two bits differ.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v[16] != v[15]) begin
      return v[16] ? 16'sh8000 : 16'sh7FFF;
    end
    return v[15:0];
  endfunction

  assign diff_wide  = $signed({sp_reg[15], sp_reg}) - $signed({fb_reg[15], fb_reg});
  assign sum_wide   = $signed({err_int[15], err_int}) + $signed({err[15], err});
  assign delta_wide = $signed({err[15], err}) - $signed({prev_err[15], prev_err});

  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sp_reg    <= '0;
      fb_reg    <= '0;
      prev_err  <= '0;
      err       <= '0;
      err_int   <= '0;
      err_diff  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A clear coinciding with a transfer lands first, so the new
          // sample accumulates from zero.
          if (clr_int) begin
            err_int  <= '0;
            prev_err <= '0;
          end
          if (in_valid) begin
            sp_reg <= setpoint;
            fb_reg <= feedback;
            state  <= SUB;
          end
        end
        SUB: begin
          err   <= sat16(diff_wide);
          state <= ACC;
        end
        ACC: begin
          if (sum_wide > LIM_HI) begin
            err_int <= I_LIMIT;
          end else if (sum_wide < LIM_LO) begin
            err_int <= -I_LIMIT;
          end else begin
            err_int <= sum_wide[15:0];
          end
          err_diff  <= sat16(delta_wide);
          prev_err  <= err;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
